// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial add/subtract controller:
// FSM encoding, nibble width and the index-counter width helper.
package nsa_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    // A WIDTH=4 instance would need zero index bits; keep at least one.
    function automatic int idx_width(input int width);
        return (width / NIB_W > 1) ? $clog2(width / NIB_W) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_adder4bit.sv
// 4-bit adder slice used by the nibble-serial controller; dataflow or
// bit-level ripple form depending on DATAFLOW_LEVEL1.
module adder4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

`ifdef DATAFLOW_LEVEL1
    assign {Cout, S} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};
`else
    logic [4:0] c;

    assign c[0] = Cin;
    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign S[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    assign Cout = c[4];
`endif

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract performed one nibble per cycle through a single
// adder4bit, LS nibble first, between valid/ready producer and consumer.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;

    logic [NIB_W-1:0]   nib_a, nib_b, nib_s;
    logic               nib_cout;

    assign nib_a = a_q[idx_q * NIB_W +: NIB_W];
    assign nib_b = b_q[idx_q * NIB_W +: NIB_W];

    adder4bit u_adder (
        .A    (nib_a),
        .B    (nib_b),
        .Cin  (carry_q),
        .S    (nib_s),
        .Cout (nib_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Subtract is A + ~B + 1, so the carry seeds to 1 and cin is unused.
                    a_d     = a;
                    b_d     = op_sub ? ~b : b;
                    carry_d = op_sub ? 1'b1 : cin;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[idx_q * NIB_W +: NIB_W] = nib_s;
                carry_d = nib_cout;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = carry_q;
    assign ovf       = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: directed cases, back-pressure,
// mid-operation reset and random operations against a signed/unsigned model.
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         op_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain unsigned and signed integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic icin, input logic isub);
        exp_t    e;
        longint  ua, ub, sa, sb, ru, rs;
        ua = longint'(ia);
        ub = longint'(ib);
        sa = longint'($signed(ia));
        sb = longint'($signed(ib));
        if (isub) begin
            ru = ua - ub;
            rs = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            ru = ua + ub + longint'(icin);
            rs = sa + sb + longint'(icin);
            e.cout = (ru >= 65536);
        end
        e.sum = ru[W-1:0];
        e.ovf = (rs > 32767) || (rs < -32768);
        return e;
    endfunction

    // Monitor: every consumer handshake retires one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else if (out_ready) begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum",  32'(sum),  32'(e.sum));
                check("cout", 32'(cout), 32'(e.cout));
                check("ovf",  32'(ovf),  32'(e.ovf));
            end
        end
    end

    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                         input logic isub, input int hold, input bit chk_lat);
        exp_t e;
        int   n;
        e        = model(ia, ib, icin, isub);
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        cin      = icin;
        op_sub   = isub;
        n        = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_wait", 32'(n), 32'd0);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
        op_sub   = 1'($urandom);
        n        = 1;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            check("out_valid_timeout", 32'(out_valid), 32'd1);
            return;
        end
        if (chk_lat) check("latency", 32'(n), 32'(NIB + 1));
        for (int i = 0; i < hold; i++) begin
            check("hold_in_ready",  32'(in_ready),  32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_sum",       32'(sum),       32'(e.sum));
            check("hold_cout",      32'(cout),      32'(e.cout));
            check("hold_ovf",       32'(ovf),       32'(e.ovf));
            in_valid = 1'b1;
            a        = W'($urandom);
            b        = W'($urandom);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_in_ready",  32'(in_ready),  32'd1);
    endtask

    task automatic reset_mid_run();
        bit seen;
        in_valid = 1'b1;
        a        = 16'h1357;
        b        = 16'h2468;
        cin      = 1'b0;
        op_sub   = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_cout",      32'(cout),      32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        check("aborted_no_out_valid", 32'(seen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum",       32'(sum),       32'd0);
        check("reset_cout",      32'(cout),      32'd0);
        check("reset_ovf",       32'(ovf),       32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 0, 1'b1);
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 1'b1);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b1);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b1);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b1);
        do_op(16'hA5A5, 16'hA5A5, 1'b0, 1'b1, 3, 1'b1);
        do_op(16'h4321, 16'h8765, 1'b1, 1'b0, 0, 1'b1);

        reset_mid_run();
        do_op(16'h1357, 16'h2468, 1'b0, 1'b0, 1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)), 1'b1);
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
